// File: rtl/serial_demux_pkg.sv
// Shared definitions for the serial demultiplexer: FSM state encodings,
// the idle/stop line level and a small elaboration-time helper.
package serial_demux_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    // Level of an idle line; also the level of a good stop bit.
    localparam logic LINE_IDLE = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Loadable down-counter with a terminal-count flag. It saturates at zero
// instead of wrapping.
module serial_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/serial_demux.sv
// Serial-to-port demultiplexer: decodes start/address/payload/stop frames,
// steers the payload bits onto the addressed port and strobes completion.
module serial_demux
    import serial_demux_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    output logic [NPORTS-1:0] port_data,
    output logic [DATA_W-1:0] port_word,
    output logic [NPORTS-1:0] port_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int ADDR_W = $clog2(NPORTS);
    localparam int CNT_W  = $clog2(max_int(ADDR_W, DATA_W) + 1);

    // The counter is loaded with (length - 1) so the last bit is taken on tc.
    localparam logic [CNT_W-1:0] ADDR_LOAD = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] payload_q;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_value;
    logic              cnt_dec;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_tc;

    logic              shift_addr;
    logic              shift_data;
    logic              good_frame;
    logic              bad_frame;

    serial_bit_counter #(
        .WIDTH (CNT_W)
    ) u_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .count      (cnt),
        .tc         (cnt_tc)
    );

    always_comb begin
        state_next     = state;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        cnt_dec        = 1'b0;
        shift_addr     = 1'b0;
        shift_data     = 1'b0;
        good_frame     = 1'b0;
        bad_frame      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (serial_in != LINE_IDLE) begin
                    state_next     = ST_ADDR;
                    cnt_load       = 1'b1;
                    cnt_load_value = ADDR_LOAD;
                end
            end
            ST_ADDR: begin
                shift_addr = 1'b1;
                if (cnt_tc) begin
                    state_next     = ST_DATA;
                    cnt_load       = 1'b1;
                    cnt_load_value = DATA_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DATA: begin
                shift_data = 1'b1;
                if (cnt_tc) begin
                    state_next = ST_STOP;
                    cnt_load   = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_STOP: begin
                cnt_load = 1'b1;
                if (serial_in == LINE_IDLE) begin
                    good_frame = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    bad_frame  = 1'b1;
                    state_next = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                // A line stuck low must not be mistaken for a new start bit.
                if (serial_in == LINE_IDLE) begin
                    state_next = ST_IDLE;
                    cnt_load   = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_load   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            payload_q  <= '0;
            port_word  <= '0;
            port_valid <= '0;
            frame_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (shift_addr) begin
                addr_q <= (addr_q << 1) | ADDR_W'(serial_in);
            end
            // Payload arrives LSB first, so bits enter at the top and drift down.
            if (shift_data) begin
                payload_q <= (payload_q >> 1) | (DATA_W'(serial_in) << (DATA_W - 1));
            end
            port_valid <= good_frame ? (NPORTS'(1) << addr_q) : '0;
            frame_err  <= bad_frame;
            if (good_frame) begin
                port_word <= payload_q;
            end
        end
    end

    always_comb begin
        port_data = '1;
        if (state == ST_DATA) begin
            port_data[addr_q] = serial_in;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_demux.sv
// Directed bench for serial_demux: default configuration plus a 16-port,
// 5-bit-payload instance.
module tb_serial_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic        serial_in;
    logic        serial_in16;

    logic [3:0]  port_data;
    logic [7:0]  port_word;
    logic [3:0]  port_valid;
    logic        frame_err;
    logic        busy;

    logic [15:0] port_data16;
    logic [4:0]  port_word16;
    logic [15:0] port_valid16;
    logic        frame_err16;
    logic        busy16;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_demux #(
        .NPORTS (4),
        .DATA_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .port_data  (port_data),
        .port_word  (port_word),
        .port_valid (port_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    serial_demux #(
        .NPORTS (16),
        .DATA_W (5)
    ) dut16 (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in16),
        .port_data  (port_data16),
        .port_word  (port_word16),
        .port_valid (port_valid16),
        .frame_err  (frame_err16),
        .busy       (busy16)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one complete frame on the default instance, starting in the
    // current cycle (cycle 0). Returns in cycle ADDR_W+DATA_W+2.
    task automatic apply_stimulus(input logic [1:0] addr, input logic [7:0] data,
                                  input logic stop);
        logic [3:0] exp_pd;
        serial_in = 1'b0;
        #1;
        check_output("busy_start", 32'(busy), 32'(1'b0));
        tick();
        for (int i = 1; i >= 0; i--) begin
            serial_in = addr[i];
            #1;
            check_output("busy_addr", 32'(busy), 32'(1'b1));
            check_output("pd_addr", 32'(port_data), 32'hF);
            check_output("valid_quiet", 32'(port_valid), 32'h0);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            serial_in = data[i];
            #1;
            exp_pd       = 4'hF;
            exp_pd[addr] = data[i];
            check_output("pd_data", 32'(port_data), 32'(exp_pd));
            check_output("valid_quiet", 32'(port_valid), 32'h0);
            tick();
        end
        serial_in = stop;
        #1;
        check_output("busy_stop", 32'(busy), 32'(1'b1));
        check_output("pd_stop", 32'(port_data), 32'hF);
        tick();
    endtask

    initial begin
        logic [15:0] exp16;
        logic [3:0]  addr16;
        logic [4:0]  data16;

        rst         = 1'b1;
        serial_in   = 1'b1;
        serial_in16 = 1'b1;
        @(posedge clk);
        #1;
        tick();

        $display("[TB] reset values");
        check_output("rst_word", 32'(port_word), 32'h0);
        check_output("rst_valid", 32'(port_valid), 32'h0);
        check_output("rst_ferr", 32'(frame_err), 32'h0);
        check_output("rst_busy", 32'(busy), 32'h0);
        check_output("rst_pd", 32'(port_data), 32'hF);
        check_output("rst_pd16", 32'(port_data16), 32'hFFFF);
        check_output("rst_word16", 32'(port_word16), 32'h0);
        rst = 1'b0;
        tick();

        $display("[TB] good frame to port 2");
        apply_stimulus(2'b10, 8'hA5, 1'b1);
        check_output("good_valid", 32'(port_valid), 32'h4);
        check_output("good_word", 32'(port_word), 32'hA5);
        check_output("good_ferr", 32'(frame_err), 32'h0);
        check_output("good_busy", 32'(busy), 32'h0);
        serial_in = 1'b1;
        tick();
        check_output("good_valid_end", 32'(port_valid), 32'h0);
        check_output("good_word_hold", 32'(port_word), 32'hA5);

        $display("[TB] bad stop bit");
        apply_stimulus(2'b10, 8'h5A, 1'b0);
        check_output("bad_ferr", 32'(frame_err), 32'h1);
        check_output("bad_valid", 32'(port_valid), 32'h0);
        check_output("bad_word", 32'(port_word), 32'hA5);
        check_output("bad_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("recover_busy", 32'(busy), 32'h1);
            check_output("recover_ferr", 32'(frame_err), 32'h0);
            check_output("recover_valid", 32'(port_valid), 32'h0);
        end
        serial_in = 1'b1;
        tick();
        check_output("recover_exit", 32'(busy), 32'h0);
        check_output("recover_word", 32'(port_word), 32'hA5);

        $display("[TB] back-to-back frames");
        apply_stimulus(2'b00, 8'h3C, 1'b1);
        check_output("b2b_valid0", 32'(port_valid), 32'h1);
        check_output("b2b_word0", 32'(port_word), 32'h3C);
        apply_stimulus(2'b11, 8'hFF, 1'b1);
        check_output("b2b_valid3", 32'(port_valid), 32'h8);
        check_output("b2b_word3", 32'(port_word), 32'hFF);
        serial_in = 1'b1;
        tick();
        check_output("b2b_valid_end", 32'(port_valid), 32'h0);

        $display("[TB] reset mid-payload");
        serial_in = 1'b0;
        tick();
        serial_in = 1'b0;
        tick();
        serial_in = 1'b1;
        tick();
        serial_in = 1'b1;
        tick();
        serial_in = 1'b0;
        tick();
        serial_in = 1'b0;
        tick();
        rst       = 1'b1;
        serial_in = 1'b0;
        tick();
        check_output("midrst_busy", 32'(busy), 32'h0);
        check_output("midrst_pd", 32'(port_data), 32'hF);
        check_output("midrst_valid", 32'(port_valid), 32'h0);
        check_output("midrst_ferr", 32'(frame_err), 32'h0);
        check_output("midrst_word", 32'(port_word), 32'h0);
        rst       = 1'b0;
        serial_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_output("midrst_quiet", 32'(port_valid), 32'h0);
            check_output("midrst_idle", 32'(busy), 32'h0);
        end
        apply_stimulus(2'b01, 8'h81, 1'b1);
        check_output("fresh_valid", 32'(port_valid), 32'h2);
        check_output("fresh_word", 32'(port_word), 32'h81);
        serial_in = 1'b1;

        $display("[TB] idle line");
        for (int i = 0; i < 50; i++) begin
            tick();
            check_output("idle_busy", 32'(busy), 32'h0);
            check_output("idle_pd", 32'(port_data), 32'hF);
            check_output("idle_valid", 32'(port_valid), 32'h0);
            check_output("idle_ferr", 32'(frame_err), 32'h0);
        end

        $display("[TB] 16-port, 5-bit payload instance");
        addr16      = 4'b1011;
        data16      = 5'h15;
        serial_in16 = 1'b0;
        tick();
        for (int i = 3; i >= 0; i--) begin
            serial_in16 = addr16[i];
            #1;
            check_output("p16_busy", 32'(busy16), 32'h1);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            serial_in16 = data16[i];
            #1;
            exp16     = 16'hFFFF;
            exp16[11] = data16[i];
            check_output("p16_pd", 32'(port_data16), 32'(exp16));
            tick();
        end
        serial_in16 = 1'b1;
        tick();
        check_output("p16_valid", 32'(port_valid16), 32'h0800);
        check_output("p16_word", 32'(port_word16), 32'h15);
        check_output("p16_ferr", 32'(frame_err16), 32'h0);
        tick();
        check_output("p16_valid_end", 32'(port_valid16), 32'h0);
        check_output("p16_busy_end", 32'(busy16), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
